// File: rtl/regbank_wb_scheduler_pkg.sv
// Shared constants and types for the register-bank writeback scheduler.
package regbank_wb_scheduler_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2 ** ADDR_W;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Which requester wins when both are valid.
  typedef enum logic {
    ARB_PRI0 = 1'b0,
    ARB_PRI1 = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regbank_wb_scheduler_if.sv
// Issue, writeback and bank-write signals of the writeback scheduler.
interface regbank_wb_scheduler_if;
  import regbank_wb_scheduler_pkg::*;

  logic              iss_valid;
  logic [ADDR_W-1:0] iss_dest;
  logic [ADDR_W-1:0] iss_srca;
  logic [ADDR_W-1:0] iss_srcb;
  logic              iss_ready;

  logic              wb0_valid;
  logic [ADDR_W-1:0] wb0_addr;
  logic [DATA_W-1:0] wb0_data;
  logic              wb0_ready;

  logic              wb1_valid;
  logic [ADDR_W-1:0] wb1_addr;
  logic [DATA_W-1:0] wb1_data;
  logic              wb1_ready;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              fwd_a;
  logic              fwd_b;
  logic              wb_err;

  modport master (
    output iss_valid, iss_dest, iss_srca, iss_srcb,
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    input  iss_ready, wb0_ready, wb1_ready,
    input  wr_en, wr_addr, wr_data, fwd_a, fwd_b, wb_err
  );

  modport slave (
    input  iss_valid, iss_dest, iss_srca, iss_srcb,
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    output iss_ready, wb0_ready, wb1_ready,
    output wr_en, wr_addr, wr_data, fwd_a, fwd_b, wb_err
  );

endinterface

// File: rtl/regbank_wb_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the winner of a contested cycle loses the next one.
module rr_arb2
  import regbank_wb_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  arb_state_e state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_PRI0;
    else     state <= state_nxt;
  end

  // Any grant hands priority to the other side, contested or not.
  always_comb begin
    state_nxt = state;
    if (grant[0])      state_nxt = ARB_PRI1;
    else if (grant[1]) state_nxt = ARB_PRI0;
  end

  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (valid == 2'b11) grant = (state == ARB_PRI0) ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end

endmodule

// File: rtl/regbank_wb_scheduler.sv
// Shares the register bank write port between ALU and load writeback, and stalls issue on
// hazards against pending writes. Define REGBANK_BYPASS_EN to forward sources from wr_data.
module regbank_wb_scheduler
  import regbank_wb_scheduler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  regbank_wb_scheduler_if.slave  bus
);

  wb_req_t           req0, req1, win;
  logic [1:0]        grant;
  logic              xfer;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wb_err;

  logic [NREG-1:0]   busy, busy_clr, busy_set;
  logic              hit_a, hit_b, ok_a, ok_b, iss_ready;

  assign req0 = '{valid: bus.wb0_valid, addr: bus.wb0_addr, data: bus.wb0_data};
  assign req1 = '{valid: bus.wb1_valid, addr: bus.wb1_addr, data: bus.wb1_data};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid ({req1.valid, req0.valid}),
    .grant (grant)
  );

  assign bus.wb0_ready = grant[0];
  assign bus.wb1_ready = grant[1];
  assign xfer          = |grant;
  assign win           = grant[1] ? req1 : req0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= xfer;
      if (xfer) begin
        wr_addr <= win.addr;
        wr_data <= win.data;
      end
    end
  end

`ifdef REGBANK_BYPASS_EN
  assign hit_a = busy[bus.iss_srca] && wr_en && (wr_addr == bus.iss_srca);
  assign hit_b = busy[bus.iss_srcb] && wr_en && (wr_addr == bus.iss_srcb);
`else
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
`endif

  // Sources may be bypassed from the commit stage; the destination never is (WAW).
  assign ok_a      = !busy[bus.iss_srca] || hit_a;
  assign ok_b      = !busy[bus.iss_srcb] || hit_b;
  assign iss_ready = bus.iss_valid && !busy[bus.iss_dest] && ok_a && ok_b && !rst;

  assign busy_clr = wr_en     ? (NREG'(1) << wr_addr)      : '0;
  assign busy_set = iss_ready ? (NREG'(1) << bus.iss_dest) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= '0;
      wb_err <= 1'b0;
    end else begin
      busy <= (busy & ~busy_clr) | busy_set;
      // A commit that finds nothing pending is a stray or duplicate writeback.
      if (wr_en && !busy[wr_addr]) wb_err <= 1'b1;
    end
  end

  assign bus.iss_ready = iss_ready;
  assign bus.fwd_a     = hit_a && bus.iss_valid && !rst;
  assign bus.fwd_b     = hit_b && bus.iss_valid && !rst;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_data   = wr_data;
  assign bus.wb_err    = wb_err;

endmodule

// File: tb/tb_regbank_wb_scheduler.sv
// Directed scenarios plus randomized traffic against a pending-write reference model.
module tb_regbank_wb_scheduler;
  import regbank_wb_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regbank_wb_scheduler_if bus();
  regbank_wb_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: set of pending destinations, one-deep commit slot, favoured requester.
  bit          mbusy [NREG];
  int          m_pref = 0;
  bit          m_wr_en = 0;
  logic [4:0]  m_wr_addr = '0;
  logic [63:0] m_wr_data = '0;
  bit          m_err = 0;
  bit          e_iss, e_g0, e_g1, e_fa, e_fb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit src_ok(input logic [4:0] s);
    if (!mbusy[s]) return 1'b1;
    return BYP && m_wr_en && (m_wr_addr == s);
  endfunction

  function automatic bit fwd_exp(input logic [4:0] s);
    return BYP && !rst && bus.iss_valid && mbusy[s] && m_wr_en && (m_wr_addr == s);
  endfunction

  task automatic predict();
    e_iss = !rst && bus.iss_valid && !mbusy[bus.iss_dest] &&
            src_ok(bus.iss_srca) && src_ok(bus.iss_srcb);
    e_fa = fwd_exp(bus.iss_srca);
    e_fb = fwd_exp(bus.iss_srcb);
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!rst) begin
      if (bus.wb0_valid && bus.wb1_valid) begin
        if (m_pref == 0) e_g0 = 1'b1; else e_g1 = 1'b1;
      end else begin
        e_g0 = bus.wb0_valid;
        e_g1 = bus.wb1_valid;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    predict();
    chk("mdl_iss_ready", bus.iss_ready, e_iss);
    chk("mdl_wb0_ready", bus.wb0_ready, e_g0);
    chk("mdl_wb1_ready", bus.wb1_ready, e_g1);
    chk("mdl_fwd_a",     bus.fwd_a,     e_fa);
    chk("mdl_fwd_b",     bus.fwd_b,     e_fb);
    chk("mdl_wr_en",     bus.wr_en,     m_wr_en);
    chk("mdl_wr_addr",   bus.wr_addr,   m_wr_addr);
    chk("mdl_wr_data",   bus.wr_data,   m_wr_data);
    chk("mdl_wb_err",    bus.wb_err,    m_err);
  endtask

  task automatic advance();
    if (rst) begin
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      m_pref = 0; m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0; m_err = 0;
    end else begin
      if (m_wr_en && !mbusy[m_wr_addr]) m_err = 1'b1;
      if (m_wr_en) mbusy[m_wr_addr] = 1'b0;
      if (e_iss) mbusy[bus.iss_dest] = 1'b1;
      m_wr_en = e_g0 || e_g1;
      if (e_g0) begin m_wr_addr = bus.wb0_addr; m_wr_data = bus.wb0_data; m_pref = 1; end
      if (e_g1) begin m_wr_addr = bus.wb1_addr; m_wr_data = bus.wb1_data; m_pref = 0; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 0; bus.iss_dest = '0; bus.iss_srca = '0; bus.iss_srcb = '0;
    bus.wb0_valid = 0; bus.wb0_addr = '0; bus.wb0_data = '0;
    bus.wb1_valid = 0; bus.wb1_addr = '0; bus.wb1_data = '0;
  endtask

  task automatic iss(input bit v, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    bus.iss_valid = v; bus.iss_dest = d; bus.iss_srca = a; bus.iss_srcb = b;
  endtask

  task automatic wb0(input bit v, input logic [4:0] a, input logic [63:0] d);
    bus.wb0_valid = v; bus.wb0_addr = a; bus.wb0_data = d;
  endtask

  task automatic wb1(input bit v, input logic [4:0] a, input logic [63:0] d);
    bus.wb1_valid = v; bus.wb1_addr = a; bus.wb1_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); settle(); advance(); rst = 1'b0;
  endtask

  initial begin
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset state and ready gating while in reset
    iss(1, 1, 2, 3);
    settle();
    chk("rst_iss_ready", bus.iss_ready, 0);
    chk("rst_wr_en",     bus.wr_en,     0);
    chk("rst_wr_addr",   bus.wr_addr,   0);
    chk("rst_wr_data",   bus.wr_data,   0);
    chk("rst_wb_err",    bus.wb_err,    0);
    advance();
    rst = 1'b0; idle();
    settle(); chk("idle_iss_ready", bus.iss_ready, 0); chk("idle_wr_en", bus.wr_en, 0); advance();

    // RAW stall on dest 5, cleared by ALU writeback
    iss(1, 5, 0, 0); settle(); chk("iss5_ready", bus.iss_ready, 1); advance();
    iss(1, 6, 5, 0); wb0(1, 5, 64'hDEAD);
    settle(); chk("raw_stall", bus.iss_ready, 0); chk("wb0_grant", bus.wb0_ready, 1); advance();
    idle();
    settle();
    chk("commit_en", bus.wr_en, 1); chk("commit_addr", bus.wr_addr, 5);
    chk("commit_data", bus.wr_data, 64'hDEAD);
    advance();
    iss(1, 6, 5, 0); settle(); chk("busy5_clear", bus.iss_ready, 1); advance();
    idle(); wb1(1, 6, 64'h66); settle(); chk("wb1_grant", bus.wb1_ready, 1); advance();
    idle(); settle(); chk("commit6_addr", bus.wr_addr, 6); advance();
    settle(); chk("no_err", bus.wb_err, 0); advance();

    // Alternating grants from reset
    do_reset();
    wb0(1, 10, 64'h100); wb1(1, 11, 64'h101);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("alt_g0", bus.wb0_ready, (i % 2) == 0);
      chk("alt_g1", bus.wb1_ready, (i % 2) == 1);
      if (i > 0) chk("alt_wr_en", bus.wr_en, 1);
      advance();
    end
    idle(); settle(); chk("alt_last_en", bus.wr_en, 1); chk("alt_last_addr", bus.wr_addr, 11); advance();

    // Stray writeback to never-issued register 9
    do_reset();
    wb1(1, 9, 64'h99); settle(); chk("err_grant", bus.wb1_ready, 1); advance();
    idle(); settle(); chk("err_commit", bus.wr_en, 1); chk("err_pre", bus.wb_err, 0); advance();
    for (int i = 0; i < 3; i++) begin
      settle(); chk("err_sticky", bus.wb_err, 1); advance();
    end
    do_reset();
    settle(); chk("err_clr", bus.wb_err, 0); advance();

    // Reset with a commit in flight
    iss(1, 4, 0, 0); settle(); chk("iss4_ready", bus.iss_ready, 1); advance();
    iss(1, 3, 0, 0); settle(); advance();
    idle(); wb0(1, 3, 64'h33); settle(); chk("pend_grant", bus.wb0_ready, 1); advance();
    rst = 1'b1; wb0(1, 3, 64'h34);
    settle(); chk("rst_no_grant", bus.wb0_ready, 0); chk("rst_pend_en", bus.wr_en, 1); advance();
    rst = 1'b0; idle(); iss(1, 4, 3, 4);
    settle(); chk("rst_drop_en", bus.wr_en, 0); chk("rst_busy_clr", bus.iss_ready, 1); advance();

    // Source bypass from the commit stage
    do_reset();
    iss(1, 7, 0, 0); settle(); advance();
    idle(); wb0(1, 7, 64'h77); settle(); advance();
    idle(); iss(1, 8, 1, 7);
    settle();
    chk("byp_wr_en", bus.wr_en, 1);
    chk("byp_ready", bus.iss_ready, BYP);
    chk("byp_fwd_b", bus.fwd_b, BYP);
    chk("byp_fwd_a", bus.fwd_a, 0);
    advance();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      iss($urandom_range(0, 1), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      wb0($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), {$urandom, $urandom});
      wb1($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), {$urandom, $urandom});
      settle();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
